// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core load/store (port 0) and loader/debug master (port 1) share one dmem.
// Latency: request seen in IDLE at cycle T -> mem strobe at T+1 -> ack/rdata at T+2; one access per 3 cycles.
// Backpressure: requesters hold req until their one-cycle ack; the loser simply waits, port 0 sees it as stall.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   pN_req/we/addr/wdata    request from port N (held stable until pN_ack)
//   pN_rdata/ack/err        completion pulse, read data and out-of-range flag for port N
//   mem_en/we/addr/wdata    memory strobe side; mem_rdata returns one cycle after a read strobe
//   stall                   core PC hold (p0_req & ~p0_ack)
//   busy                    FSM not idle
//   gnt_cnt0/1              completed-transaction counters (wrap), errors included
//
// Optional build macro DMEM_ARB_FIXED_PRIO_EN: when defined, port 0 always wins a tie (port 1 may
// starve); when undefined, ties alternate round-robin with port 0 winning the first tie after reset.

module dmem_arbiter #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_0400,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             p0_req,
    input  logic             p0_we,
    input  logic [31:0]      p0_addr,
    input  logic [31:0]      p0_wdata,
    output logic [31:0]      p0_rdata,
    output logic             p0_ack,
    output logic             p0_err,

    input  logic             p1_req,
    input  logic             p1_we,
    input  logic [31:0]      p1_addr,
    input  logic [31:0]      p1_wdata,
    output logic [31:0]      p1_rdata,
    output logic             p1_ack,
    output logic             p1_err,

    output logic             mem_en,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,

    output logic             stall,
    output logic             busy,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state;
    state_t      state_nxt;

    // Transaction latched at grant time; later input changes are ignored.
    logic        lat_port;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        err_pending;

    logic        pick_p1;
    logic        addr_ok;
    logic [31:0] resp_rdata;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Port 0 has absolute priority.
    assign pick_p1 = p1_req & ~p0_req;
`else
    // Last winner; reset to 1 so port 0 takes the first tie.
    logic rr_last;

    // On a tie the port that did not win last time goes next.
    assign pick_p1 = p1_req & (~p0_req | ~rr_last);
`endif

    assign addr_ok = (lat_addr < ADDR_LIMIT);

    // State register and datapath latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lat_port    <= 1'b0;
            lat_we      <= 1'b0;
            lat_addr    <= 32'd0;
            lat_wdata   <= 32'd0;
            err_pending <= 1'b0;
            gnt_cnt0    <= '0;
            gnt_cnt1    <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            rr_last     <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        lat_port  <= pick_p1;
                        lat_we    <= pick_p1 ? p1_we    : p0_we;
                        lat_addr  <= pick_p1 ? p1_addr  : p0_addr;
                        lat_wdata <= pick_p1 ? p1_wdata : p0_wdata;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                        rr_last   <= pick_p1;
`endif
                    end
                end
                ISSUE: begin
                    err_pending <= ~addr_ok;
                end
                RESP: begin
                    if (lat_port) begin
                        gnt_cnt1 <= gnt_cnt1 + CNT_ONE;
                    end else begin
                        gnt_cnt0 <= gnt_cnt0 + CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and outputs.
    always_comb begin
        state_nxt  = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        p0_ack     = 1'b0;
        p0_err     = 1'b0;
        p0_rdata   = 32'd0;
        p1_ack     = 1'b0;
        p1_err     = 1'b0;
        p1_rdata   = 32'd0;
        resp_rdata = 32'd0;

        case (state)
            IDLE: begin
                if (p0_req || p1_req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // Out-of-range accesses never reach memory.
                if (addr_ok) begin
                    mem_en    = 1'b1;
                    mem_we    = lat_we;
                    mem_addr  = lat_addr;
                    mem_wdata = lat_wdata;
                end
                state_nxt = RESP;
            end
            RESP: begin
                // mem_rdata may still hold an older read; only pass it for a legal read.
                if (!lat_we && !err_pending) begin
                    resp_rdata = mem_rdata;
                end
                if (lat_port) begin
                    p1_ack   = 1'b1;
                    p1_err   = err_pending;
                    p1_rdata = resp_rdata;
                end else begin
                    p0_ack   = 1'b1;
                    p0_err   = err_pending;
                    p0_rdata = resp_rdata;
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign stall = p0_req & ~p0_ack;
    assign busy  = (state != IDLE);

endmodule
